// File: rtl/xheep_boot_seq_pkg.sv
// ============================================================================
// xheep_boot_seq_pkg : shared types and defaults for the X-HEEP boot sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package xheep_boot_seq_pkg;

  localparam int unsigned EXIT_VALUE_W = 32;

  localparam int unsigned DEF_RST_HOLD_CYCLES   = 16;
  localparam int unsigned DEF_TRST_DELAY_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT_W         = 32;
  localparam int unsigned DEF_SYNC_STAGES       = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    TRST    = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4,
    TIMEOUT = 3'd5
  } boot_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xheep_boot_seq_sync.sv
// ============================================================================
// xheep_boot_seq_sync : N-bit multi-stage flop synchronizer, sync active-low rst
// Revision: 1.0
// ============================================================================
`default_nettype none

module xheep_boot_seq_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/xheep_boot_sequencer.sv
// ============================================================================
// xheep_boot_sequencer : PS-driven reset/boot sequencer for x_heep_system
// Revision: 1.0
// ============================================================================
`default_nettype none

module xheep_boot_sequencer
  import xheep_boot_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES   = DEF_RST_HOLD_CYCLES,
  parameter int unsigned TRST_DELAY_CYCLES = DEF_TRST_DELAY_CYCLES,
  parameter int unsigned TIMEOUT_W         = DEF_TIMEOUT_W,
  parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    boot_select_cfg_i,
  input  logic                    exec_flash_cfg_i,
  input  logic [TIMEOUT_W-1:0]    timeout_cycles_i,
  input  logic                    exit_valid_i,
  input  logic [EXIT_VALUE_W-1:0] exit_value_i,
  output logic                    core_rst_no,
  output logic                    jtag_trst_no,
  output logic                    boot_select_o,
  output logic                    execute_from_flash_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [EXIT_VALUE_W-1:0] exit_value_o,
  output logic [TIMEOUT_W-1:0]    cycle_count_o
);

  localparam int unsigned PH_MAX = max_u(RST_HOLD_CYCLES, TRST_DELAY_CYCLES);
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;

  localparam logic [PH_W-1:0] HOLD_LOAD = PH_W'(RST_HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] TRST_LOAD = PH_W'(TRST_DELAY_CYCLES - 1);

  logic [3:0] sync_in_s;
  logic [3:0] sync_out_s;
  logic       start_s;
  logic       abort_s;
  logic       boot_cfg_s;
  logic       flash_cfg_s;
  logic       start_rise_s;
  logic       timeout_hit_s;

  assign sync_in_s = {start_i, abort_i, boot_select_cfg_i, exec_flash_cfg_i};

  xheep_boot_seq_sync #(
    .WIDTH  (4),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .data_i (sync_in_s),
    .data_o (sync_out_s)
  );

  assign {start_s, abort_s, boot_cfg_s, flash_cfg_s} = sync_out_s;

  boot_state_e              state_q;
  logic [PH_W-1:0]          phase_q;
  logic                     start_sync_q;
  logic                     core_rst_n_q;
  logic                     jtag_trst_n_q;
  logic                     boot_select_q;
  logic                     exec_flash_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     timeout_q;
  logic [EXIT_VALUE_W-1:0]  exit_value_q;
  logic [TIMEOUT_W-1:0]     cycle_count_q;

  assign start_rise_s  = start_s & ~start_sync_q;
  assign timeout_hit_s = (timeout_cycles_i != '0) && (cycle_count_q == timeout_cycles_i);

  // Outputs are set on the edge that enters each state, so they are all flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      start_sync_q  <= 1'b0;
      core_rst_n_q  <= 1'b0;
      jtag_trst_n_q <= 1'b0;
      boot_select_q <= 1'b0;
      exec_flash_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      exit_value_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      start_sync_q <= start_s;
      if (abort_s) begin
        state_q       <= IDLE;
        phase_q       <= '0;
        core_rst_n_q  <= 1'b0;
        jtag_trst_n_q <= 1'b0;
        busy_q        <= 1'b0;
        done_q        <= 1'b0;
        timeout_q     <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE, TIMEOUT: begin
            if (start_rise_s) begin
              state_q       <= HOLD;
              phase_q       <= HOLD_LOAD;
              boot_select_q <= boot_cfg_s;
              exec_flash_q  <= flash_cfg_s;
              core_rst_n_q  <= 1'b0;
              jtag_trst_n_q <= 1'b0;
              busy_q        <= 1'b1;
              done_q        <= 1'b0;
              timeout_q     <= 1'b0;
              exit_value_q  <= '0;
              cycle_count_q <= '0;
            end
          end
          HOLD: begin
            if (phase_q == '0) begin
              state_q       <= TRST;
              phase_q       <= TRST_LOAD;
              jtag_trst_n_q <= 1'b1;
            end else begin
              phase_q <= phase_q - 1'b1;
            end
          end
          TRST: begin
            if (phase_q == '0) begin
              state_q       <= RUN;
              phase_q       <= '0;
              core_rst_n_q  <= 1'b1;
              cycle_count_q <= '0;
            end else begin
              phase_q <= phase_q - 1'b1;
            end
          end
          RUN: begin
            // The count is frozen on the exit edge so it reports completed RUN cycles.
            if (exit_valid_i) begin
              state_q      <= DONE;
              phase_q      <= '0;
              exit_value_q <= exit_value_i;
              core_rst_n_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else if (timeout_hit_s) begin
              state_q      <= TIMEOUT;
              phase_q      <= '0;
              core_rst_n_q <= 1'b0;
              busy_q       <= 1'b0;
              timeout_q    <= 1'b1;
            end else if (cycle_count_q != {TIMEOUT_W{1'b1}}) begin
              cycle_count_q <= cycle_count_q + 1'b1;
            end
          end
          default: begin
            state_q       <= IDLE;
            phase_q       <= '0;
            core_rst_n_q  <= 1'b0;
            jtag_trst_n_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign core_rst_no          = core_rst_n_q;
  assign jtag_trst_no         = jtag_trst_n_q;
  assign boot_select_o        = boot_select_q;
  assign execute_from_flash_o = exec_flash_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign timeout_o            = timeout_q;
  assign exit_value_o         = exit_value_q;
  assign cycle_count_o        = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_xheep_boot_sequencer.sv
// ============================================================================
// tb_xheep_boot_sequencer : directed scoreboard bench for xheep_boot_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xheep_boot_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        boot_select_cfg_i = 1'b0;
  logic        exec_flash_cfg_i = 1'b0;
  logic [31:0] timeout_cycles_i = '0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;
  logic        core_rst_no;
  logic        jtag_trst_no;
  logic        boot_select_o;
  logic        execute_from_flash_o;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic [31:0] exit_value_o;
  logic [31:0] cycle_count_o;

  xheep_boot_sequencer #(
    .RST_HOLD_CYCLES   (16),
    .TRST_DELAY_CYCLES (4),
    .TIMEOUT_W         (32),
    .SYNC_STAGES       (2)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .start_i              (start_i),
    .abort_i              (abort_i),
    .boot_select_cfg_i    (boot_select_cfg_i),
    .exec_flash_cfg_i     (exec_flash_cfg_i),
    .timeout_cycles_i     (timeout_cycles_i),
    .exit_valid_i         (exit_valid_i),
    .exit_value_i         (exit_value_i),
    .core_rst_no          (core_rst_no),
    .jtag_trst_no         (jtag_trst_no),
    .boot_select_o        (boot_select_o),
    .execute_from_flash_o (execute_from_flash_o),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .timeout_o            (timeout_o),
    .exit_value_o         (exit_value_o),
    .cycle_count_o        (cycle_count_o)
  );

  always #5 clk_i = ~clk_i;

  int edge_n = 0;
  always @(posedge clk_i) edge_n = edge_n + 1;

  // ctl = {core_rst_no, jtag_trst_no, boot_select, exec_flash, busy, done, timeout}
  typedef struct packed {
    logic [63:0] name;
    logic [31:0] at;
    logic [6:0]  ctl;
    logic [31:0] ev;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic mon_first = 1'b1;
  logic [6:0] prev_ctl = '0;

  logic [6:0] snap;
  assign snap = {core_rst_no, jtag_trst_no, boot_select_o, execute_from_flash_o,
                 busy_o, done_o, timeout_o};

  task automatic expect_ev(input logic [63:0] nm, input int at, input logic [6:0] ctl,
                           input logic [31:0] ev, input logic [31:0] cnt);
    exp_t e;
    e.name = nm;
    e.at   = at;
    e.ctl  = ctl;
    e.ev   = ev;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Monitor: every change of the control vector is one DUT response.
  always @(negedge clk_i) begin
    if (mon_en && (mon_first || snap != prev_ctl)) begin
      exp_t e;
      mon_first = 1'b0;
      prev_ctl  = snap;
      n_assert  = n_assert + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_change edge=%0d ctl=%b ev=%h cnt=%0d required=no change",
                 edge_n, snap, exit_value_o, cycle_count_o);
      end else begin
        e = exp_q.pop_front();
        if (snap !== e.ctl || exit_value_o !== e.ev || cycle_count_o !== e.cnt ||
            edge_n != int'(e.at)) begin
          n_fail = n_fail + 1;
          $display("FAIL %s actual: edge=%0d ctl=%b ev=%h cnt=%0d required: edge=%0d ctl=%b ev=%h cnt=%0d",
                   e.name, edge_n, snap, exit_value_o, cycle_count_o,
                   e.at, e.ctl, e.ev, e.cnt);
        end
      end
    end
  end

  initial begin
    boot_select_cfg_i = 1'b1;
    exec_flash_cfg_i  = 1'b0;

    // Reset
    expect_ev("RESET", 5, 7'b0000000, 32'h0, 32'd0);
    wait_edge(5);
    mon_en = 1'b1;
    rst_ni = 1'b1;

    // Run 1: boot=1 flash=0, exit at RUN cycle 100
    wait_edge(8);
    start_i = 1'b1;
    expect_ev("HOLD1", 11, 7'b0010100, 32'h0, 32'd0);
    expect_ev("TRST1", 27, 7'b0110100, 32'h0, 32'd0);
    expect_ev("RUN1",  31, 7'b1110100, 32'h0, 32'd0);
    wait_edge(10);
    start_i = 1'b0;
    wait_edge(15);
    exit_valid_i = 1'b1;
    exit_value_i = 32'hDEAD_BEEF;
    wait_edge(16);
    exit_valid_i = 1'b0;
    wait_edge(40);
    boot_select_cfg_i = 1'b0;
    exec_flash_cfg_i  = 1'b1;
    wait_edge(131);
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_0001;
    expect_ev("DONE1", 132, 7'b0110010, 32'h1, 32'd100);
    wait_edge(132);
    exit_valid_i = 1'b0;
    exit_value_i = 32'h1234_5678;
    wait_edge(135);
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_0055;
    wait_edge(136);
    exit_valid_i = 1'b0;

    // Run 2 from DONE: boot=0 flash=1, watchdog 50
    wait_edge(140);
    timeout_cycles_i = 32'd50;
    start_i = 1'b1;
    expect_ev("HOLD2", 143, 7'b0001100, 32'h0, 32'd0);
    expect_ev("TRST2", 159, 7'b0101100, 32'h0, 32'd0);
    expect_ev("RUN2",  163, 7'b1101100, 32'h0, 32'd0);
    expect_ev("TMO2",  214, 7'b0101001, 32'h0, 32'd50);
    wait_edge(142);
    start_i = 1'b0;

    // Run 3 from TIMEOUT: abort during HOLD, start toggled under abort
    wait_edge(215);
    boot_select_cfg_i = 1'b1;
    exec_flash_cfg_i  = 1'b1;
    timeout_cycles_i  = 32'd20;
    wait_edge(220);
    start_i = 1'b1;
    expect_ev("HOLD3", 223, 7'b0011100, 32'h0, 32'd0);
    expect_ev("ABRTH", 231, 7'b0011000, 32'h0, 32'd0);
    wait_edge(222);
    start_i = 1'b0;
    wait_edge(228);
    abort_i = 1'b1;
    wait_edge(235);
    start_i = 1'b1;
    wait_edge(240);
    start_i = 1'b0;
    wait_edge(245);
    start_i = 1'b1;
    wait_edge(250);
    start_i = 1'b0;
    wait_edge(252);
    abort_i = 1'b0;

    // Run 4: exit coincides with watchdog match at 20
    wait_edge(260);
    start_i = 1'b1;
    expect_ev("HOLD4", 263, 7'b0011100, 32'h0, 32'd0);
    expect_ev("TRST4", 279, 7'b0111100, 32'h0, 32'd0);
    expect_ev("RUN4",  283, 7'b1111100, 32'h0, 32'd0);
    wait_edge(262);
    start_i = 1'b0;
    wait_edge(303);
    exit_valid_i = 1'b1;
    exit_value_i = 32'hCAFE_F00D;
    expect_ev("DONE4", 304, 7'b0111010, 32'hCAFE_F00D, 32'd20);
    wait_edge(304);
    exit_valid_i = 1'b0;

    // Run 5: watchdog disabled, long run, then abort during RUN
    wait_edge(305);
    timeout_cycles_i = 32'd0;
    wait_edge(310);
    start_i = 1'b1;
    expect_ev("HOLD5", 313, 7'b0011100, 32'h0, 32'd0);
    expect_ev("TRST5", 329, 7'b0111100, 32'h0, 32'd0);
    expect_ev("RUN5",  333, 7'b1111100, 32'h0, 32'd0);
    wait_edge(312);
    start_i = 1'b0;
    wait_edge(10333);
    abort_i = 1'b1;
    expect_ev("ABRTR", 10336, 7'b0011000, 32'h0, 32'd10002);
    wait_edge(10340);
    abort_i = 1'b0;

    // Run 6: reset asserted mid-RUN
    wait_edge(10350);
    start_i = 1'b1;
    expect_ev("HOLD6", 10353, 7'b0011100, 32'h0, 32'd0);
    expect_ev("TRST6", 10369, 7'b0111100, 32'h0, 32'd0);
    expect_ev("RUN6",  10373, 7'b1111100, 32'h0, 32'd0);
    wait_edge(10352);
    start_i = 1'b0;
    wait_edge(10380);
    rst_ni = 1'b0;
    expect_ev("RSTRUN", 10381, 7'b0000000, 32'h0, 32'd0);
    wait_edge(10385);
    rst_ni = 1'b1;
    wait_edge(10395);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_assert = n_assert + 1;
      n_fail   = n_fail + 1;
      $display("FAIL %s actual: never observed required: edge=%0d ctl=%b ev=%h cnt=%0d",
               e.name, e.at, e.ctl, e.ev, e.cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xheep_boot_sequencer.md
Name: xheep_boot_sequencer

Overview:
- Controller between the PS GPIO/JTAG bridge and x_heep_system on PS-enabled FPGA targets.
- Sequences core reset, JTAG TRST, boot_select and execute_from_flash from PS commands. Captures exit_valid/exit_value, enforces an optional run-timeout watchdog and reports status back to the PS.
- Replaces direct wiring of PS GPIO bits to x_heep_system control pins.

Parameters:
- RST_HOLD_CYCLES, 16: cycles core and JTAG stay in reset after start; must be >=1.
- TRST_DELAY_CYCLES, 4: cycles between jtag_trst_no release and core_rst_no release; must be >=1.
- TIMEOUT_W, 32: width of the timeout and cycle counters.
- SYNC_STAGES, 2: synchronizer depth for PS-side inputs; must be >=2.

Ports:
- clk_i  in  1  system clock (clk_gen domain)
- rst_ni  in  1  synchronous, active-low reset
- start_i  in  1  PS level, asynchronous; rising edge requests a run
- abort_i  in  1  PS level, asynchronous; high forces IDLE
- boot_select_cfg_i  in  1  PS boot_select request, asynchronous
- exec_flash_cfg_i  in  1  PS execute_from_flash request, asynchronous
- timeout_cycles_i  in  TIMEOUT_W  run watchdog limit, quasi-static; 0 disables it
- exit_valid_i  in  1  from x_heep_system exit_valid_o
- exit_value_i  in  32  from x_heep_system exit_value_o
- core_rst_no  out  1  to x_heep_system rst_ni
- jtag_trst_no  out  1  to x_heep_system jtag_trst_ni
- boot_select_o  out  1  to x_heep_system boot_select_i
- execute_from_flash_o  out  1  to x_heep_system execute_from_flash_i
- busy_o  out  1  high in HOLD, TRST or RUN
- done_o  out  1  high in DONE
- timeout_o  out  1  high in TIMEOUT
- exit_value_o  out  32  captured exit value
- cycle_count_o  out  TIMEOUT_W  cycles spent in RUN

Behaviour:
- One clock. Reset is synchronous, active-low. All outputs are registered.
- Values while rst_ni=0:
  - state = IDLE
  - core_rst_no, jtag_trst_no, boot_select_o, execute_from_flash_o = 0
  - busy_o, done_o, timeout_o = 0
  - exit_value_o, cycle_count_o = 0
  - synchronizer flops = 0, start edge-detect register = 0
- Input conditioning:
  - start_i, abort_i and both cfg bits pass through SYNC_STAGES flops.
  - start_rise = start_sync & ~start_sync_q.
  - Internal signals use the _s suffix.
- States:
  - IDLE: core_rst_no=0, jtag_trst_no=0. On start_rise & ~abort_s, latch cfg_s into boot_select_o/execute_from_flash_o, clear exit_value_o, cycle_count_o, done_o and timeout_o, then go to HOLD.
  - HOLD: both resets asserted for exactly RST_HOLD_CYCLES cycles, then go to TRST.
  - TRST: jtag_trst_no=1, core_rst_no=0 for exactly TRST_DELAY_CYCLES cycles, then go to RUN.
  - RUN: core_rst_no=1, jtag_trst_no=1.
    - cycle_count_o starts at 0 on entry and increments every RUN cycle, saturating at all-ones.
    - If exit_valid_i=1: exit_value_o <= exit_value_i and go to DONE.
    - Else if timeout_cycles_i!=0 and cycle_count_o==timeout_cycles_i: go to TIMEOUT.
  - DONE: done_o=1, core_rst_no=0 (core frozen), jtag_trst_no=1. exit_value_o and cycle_count_o are held. start_rise goes to HOLD with the same latching as IDLE.
  - TIMEOUT: timeout_o=1, core_rst_no=0, otherwise identical to DONE.
- Priority in any cycle: abort_s > exit_valid_i > timeout > start_rise.
- Abort:
  - abort_s=1 in any state forces IDLE on the next edge and clears done_o, timeout_o and busy_o.
  - exit_value_o and cycle_count_o are retained.
  - start_rise is ignored while abort_s=1.
- start_rise is ignored in HOLD, TRST and RUN.
- exit_valid_i is ignored outside RUN.
- boot_select_o/execute_from_flash_o change only at the start latch. cfg edits mid-run have no effect.
- Latency: a start_i rising edge reaches HOLD SYNC_STAGES+1 edges after first being sampled high. core_rst_no rises RST_HOLD_CYCLES+TRST_DELAY_CYCLES cycles after HOLD entry.
- Phase counter:
  - Width is $clog2(max(RST_HOLD_CYCLES,TRST_DELAY_CYCLES))+1.
  - Reloaded on every state change.
  - Separate from cycle_count_o.

Decomposition:
- Package xheep_boot_seq_pkg holds:
  - state enum: IDLE, HOLD, TRST, RUN, DONE, TIMEOUT
  - EXIT_VALUE_W = 32
  - default parameter constants
- One sub-module, xheep_boot_seq_sync: a parametric N-bit, SYNC_STAGES-deep flop synchronizer with synchronous active-low reset. It is instantiated once for the 4 PS inputs.
- FSM and counters live in the top module.

Test Plan:
- Reset then start, no abort, cfg boot=1/flash=0:
  - HOLD entered SYNC_STAGES+1 edges after start.
  - jtag_trst_no rises after 16 cycles; core_rst_no rises 4 cycles later.
  - boot_select_o=1, execute_from_flash_o=0.
- RUN, exit_valid_i pulses at RUN cycle 100 with exit_value_i=0x0000_0001 -> DONE, done_o=1, exit_value_o=1, cycle_count_o=100, core_rst_no=0.
- timeout_cycles_i=50, exit_valid_i never asserted -> TIMEOUT after cycle_count_o==50, timeout_o=1, core_rst_no=0. timeout_cycles_i=0 -> stays in RUN for 10000 cycles.
- abort_i raised during HOLD and during RUN -> IDLE, both resets 0, busy_o=0. start_i toggled while abort_i high -> no transition.
- exit_valid_i=1 in the same cycle as timeout match (timeout_cycles_i=20) -> DONE, not TIMEOUT. exit_valid_i during HOLD -> ignored.
- Second start from DONE with cfg flash=1 -> flags and exit_value_o cleared, execute_from_flash_o=1, full sequence repeats. rst_ni asserted mid-RUN -> all outputs return to reset values on the next edge.
